input_debouncer: RTL and testbench

- Upstream conditioning stage for the level-to-pulse converter.
- Takes a raw, asynchronous, possibly bouncing level (pushbutton or external strobe) and synchronises it into the clk domain.
- Qualifies the level with a stability counter, then presents a clean registered level. The pulse-generation stage consumes that level as its X input.

---
 rtl/input_debouncer.sv | 112 +++++++++++
 tb/tb_input_debouncer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Synchronises a raw asynchronous level and qualifies every change with a stability counter
// before presenting it as a clean registered level.
module input_debouncer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic x_raw,
  input  logic enable,
  output logic x_clean,
  output logic busy
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("input_debouncer: SYNC_STAGES must be in 2..4");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce_cycles
    $error("input_debouncer: DEBOUNCE_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    StStableLow,
    StWaitHigh,
    StStableHigh,
    StWaitLow
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   x_sync;
  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   x_clean_q, busy_q;

  assign x_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], x_raw};
    end
  end

  // Any disagreeing sample or loss of enable drops back to the stable state, taking
  // priority over the terminal count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StStableLow: begin
        if (enable && x_sync) begin
          state_d = StWaitHigh;
          cnt_d   = '0;
        end
      end
      StWaitHigh: begin
        if (!x_sync || !enable) begin
          state_d = StStableLow;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StStableHigh;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStableHigh: begin
        if (enable && !x_sync) begin
          state_d = StWaitLow;
          cnt_d   = '0;
        end
      end
      StWaitLow: begin
        if (x_sync || !enable) begin
          state_d = StStableHigh;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StStableLow;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StStableLow;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StStableLow;
      cnt_q     <= '0;
      x_clean_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      x_clean_q <= (state_d == StStableHigh) || (state_d == StWaitLow);
      busy_q    <= (state_d == StWaitHigh) || (state_d == StWaitLow);
    end
  end

  assign x_clean = x_clean_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: default and small-parameter instances share stimulus and are
// compared every cycle against a sample-window model, plus directed vectors and sequences.
module tb_input_debouncer;

  logic clk;
  logic rstn;
  logic x_raw;
  logic enable;
  logic x_clean0, busy0;
  logic x_clean1, busy1;

  int checks = 0;
  int errors = 0;

  input_debouncer #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(16)
  ) dut0 (
    .clk    (clk),
    .rstn   (rstn),
    .x_raw  (x_raw),
    .enable (enable),
    .x_clean(x_clean0),
    .busy   (busy0)
  );

  input_debouncer #(
    .SYNC_STAGES    (3),
    .DEBOUNCE_CYCLES(4)
  ) dut1 (
    .clk    (clk),
    .rstn   (rstn),
    .x_raw  (x_raw),
    .enable (enable),
    .x_clean(x_clean1),
    .busy   (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each instance sees x_raw delayed by its synchroniser depth; a change is
  // accepted once DEBOUNCE_CYCLES+1 consecutive enabled edges all see the opposite level.
  int ss [2] = '{2, 3};
  int dc [2] = '{16, 4};
  bit line0[$];
  bit line1[$];
  bit m_clean [2];
  int m_run [2];

  task automatic model_reset();
    line0 = {};
    line1 = {};
    for (int i = 0; i < ss[0]; i++) line0.push_back(1'b0);
    for (int i = 0; i < ss[1]; i++) line1.push_back(1'b0);
    for (int k = 0; k < 2; k++) begin
      m_clean[k] = 1'b0;
      m_run[k]   = 0;
    end
  endtask

  task automatic model_edge(input int k, input bit xr, input bit en);
    bit xs;
    bit good;
    if (k == 0) begin
      xs = line0.pop_front();
      line0.push_back(xr);
    end else begin
      xs = line1.pop_front();
      line1.push_back(xr);
    end
    good = en && (xs != m_clean[k]);
    m_run[k] = good ? m_run[k] + 1 : 0;
    if (m_run[k] == dc[k] + 1) begin
      m_clean[k] = !m_clean[k];
      m_run[k]   = 0;
    end
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive at the falling edge, clock once, then compare both instances against the model.
  task automatic step(input bit xr, input bit en);
    x_raw  = xr;
    enable = en;
    @(posedge clk);
    model_edge(0, xr, en);
    model_edge(1, xr, en);
    @(negedge clk);
    chk("model_clean0", x_clean0, m_clean[0]);
    chk("model_busy0", busy0, m_run[0] != 0);
    chk("model_clean1", x_clean1, m_clean[1]);
    chk("model_busy1", busy1, m_run[1] != 0);
  endtask

  // Reset lands mid-cycle (between falling and rising edge) and must clear outputs at once.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("reset_clean0", x_clean0, 1'b0);
    chk("reset_busy0", busy0, 1'b0);
    chk("reset_clean1", x_clean1, 1'b0);
    chk("reset_busy1", busy1, 1'b0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  typedef struct {
    bit x;
    bit en;
    int hold;
    bit exp_clean;
    bit exp_busy;
  } vec_t;

  localparam int NumVecs = 18;
  vec_t vecs [NumVecs];

  initial begin
    bit xv;
    bit ev;
    int len;

    rstn   = 1'b0;
    x_raw  = 1'b0;
    enable = 1'b1;
    model_reset();

    // Expected outputs of the default instance after each entry's hold edges.
    vecs[0]  = '{1'b1, 1'b1, 2,  1'b0, 1'b0};  // not yet through the synchroniser
    vecs[1]  = '{1'b1, 1'b1, 1,  1'b0, 1'b1};  // edge 2: qualification starts
    vecs[2]  = '{1'b1, 1'b1, 15, 1'b0, 1'b1};  // edge 17: still qualifying
    vecs[3]  = '{1'b1, 1'b1, 1,  1'b1, 1'b0};  // edge 18: accepted
    vecs[4]  = '{1'b0, 1'b1, 18, 1'b1, 1'b1};  // falling side qualifying
    vecs[5]  = '{1'b0, 1'b1, 1,  1'b0, 1'b0};  // falls after edge 18
    vecs[6]  = '{1'b1, 1'b1, 16, 1'b0, 1'b1};  // exactly 16 high samples
    vecs[7]  = '{1'b0, 1'b1, 2,  1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1,  1'b0, 1'b0};  // rejected
    vecs[9]  = '{1'b0, 1'b1, 3,  1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 17, 1'b0, 1'b1};  // 17 high samples
    vecs[11] = '{1'b0, 1'b1, 2,  1'b1, 1'b0};  // accepted at edge 18
    vecs[12] = '{1'b0, 1'b1, 16, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1,  1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 11, 1'b0, 1'b1};  // cnt reaches 8
    vecs[15] = '{1'b1, 1'b0, 3,  1'b0, 1'b0};  // enable drop aborts
    vecs[16] = '{1'b1, 1'b1, 16, 1'b0, 1'b1};  // full restart
    vecs[17] = '{1'b1, 1'b1, 1,  1'b1, 1'b0};

    do_reset();
    for (int i = 0; i < NumVecs; i++) begin
      repeat (vecs[i].hold) step(vecs[i].x, vecs[i].en);
      chk($sformatf("vec%0d_clean", i), x_clean0, vecs[i].exp_clean);
      chk($sformatf("vec%0d_busy", i), busy0, vecs[i].exp_busy);
    end

    // Asynchronous reset with x_clean high, then a rise from reset with x_raw held.
    chk("pre_reset_clean0", x_clean0, 1'b1);
    do_reset();
    repeat (18) step(1'b1, 1'b1);
    chk("post_reset_e17_clean0", x_clean0, 1'b0);
    chk("post_reset_e17_busy0", busy0, 1'b1);
    step(1'b1, 1'b1);
    chk("post_reset_e18_clean0", x_clean0, 1'b1);
    chk("post_reset_e18_busy0", busy0, 1'b0);

    // Bounce from the high state; last low sample begins at relative edge 9.
    for (int i = 0; i < 10; i++) begin
      step((i % 2) == 0, 1'b1);
      chk("bounce_hold_clean0", x_clean0, 1'b1);
    end
    repeat (17) step(1'b0, 1'b1);
    chk("bounce_e26_clean0", x_clean0, 1'b1);
    step(1'b0, 1'b1);
    chk("bounce_e27_clean0", x_clean0, 1'b0);
    chk("bounce_e27_busy0", busy0, 1'b0);

    // Small instance: rise latency of 7 edges.
    do_reset();
    repeat (7) step(1'b1, 1'b1);
    chk("small_e6_clean1", x_clean1, 1'b0);
    chk("small_e6_busy1", busy1, 1'b1);
    step(1'b1, 1'b1);
    chk("small_e7_clean1", x_clean1, 1'b1);
    chk("small_e7_busy1", busy1, 1'b0);

    // Small instance: 4-sample glitch lands a bounce on the terminal edge and is rejected.
    do_reset();
    repeat (4) step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    chk("glitch_e6_busy1", busy1, 1'b1);
    step(1'b0, 1'b1);
    chk("glitch_e7_clean1", x_clean1, 1'b0);
    chk("glitch_e7_busy1", busy1, 1'b0);

    // Small instance: enable falling on the terminal edge aborts.
    do_reset();
    repeat (7) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    chk("term_abort_clean1", x_clean1, 1'b0);
    chk("term_abort_busy1", busy1, 1'b0);

    // Random segments of held levels with occasional single-cycle glitches.
    do_reset();
    for (int seg = 0; seg < 250; seg++) begin
      xv  = 1'($urandom_range(0, 1));
      ev  = ($urandom_range(0, 7) != 0);
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 9) == 0) step(!xv, ev);
        else step(xv, ev);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
